// File: rtl/seg7_capture_if.sv
// Bus between a multiplexed 7-segment drive and its capture monitor.
// The drive side supplies segments and digit select. The monitor returns
// the decoded frame.
interface seg7_capture_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic        frame_valid;
    logic        frame_err;

    modport master (
        output seg,
        output an,
        input  digits,
        input  frame_valid,
        input  frame_err
    );

    modport slave (
        input  seg,
        input  an,
        output digits,
        output frame_valid,
        output frame_err
    );
endinterface

// File: rtl/seg7_capture.sv
// Readback monitor for a multiplexed 4-digit 7-segment drive.
// A (select, pattern) pair is accepted only after it has been stable for
// STABLE_CYCLES registered samples. Each accepted pattern is decoded back
// to BCD. A full 4-digit frame is published with a one-cycle strobe.
//
// state    | meaning
// ---------+---------------------------------------------------------
// QUALIFY  | waiting for the current dwell to reach the stability count
// HELD     | dwell already captured; wait for the sample to change
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    seg7_capture_if.slave bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_QUALIFY,
        ST_HELD
    } state_t;

    state_t          state_q;
    logic [6:0]      s_seg_q;
    logic [3:0]      s_an_q;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      mask_q, mask_d;
    logic            err_pend_q, err_pend_d;
    logic [3:0][3:0] slot_q, slot_d;
    logic [15:0]     digits_q;
    logic            frame_valid_q;
    logic            frame_err_q;

    logic            sample_same;
    logic [3:0]      dec_nib;
    logic            dec_ill;
    logic [1:0]      slot_idx;
    logic            capture;
    logic            publish;

    // Stability count of the sample being loaded into the input stage.
    // The count restarts when that sample differs from the one already held,
    // or when the digit select is not one-hot.
    always_comb begin
        sample_same = (bus.an == s_an_q) && (bus.seg == s_seg_q);
        if (!sample_same || !$onehot(bus.an)) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Map the registered segment pattern back to a BCD nibble.
    // Blank maps to F. Anything unrecognised maps to E and is flagged.
    always_comb begin
        dec_ill = 1'b0;
        case (s_seg_q)
            7'h7E:   dec_nib = 4'h0;
            7'h30:   dec_nib = 4'h1;
            7'h6D:   dec_nib = 4'h2;
            7'h79:   dec_nib = 4'h3;
            7'h33:   dec_nib = 4'h4;
            7'h5B:   dec_nib = 4'h5;
            7'h5F:   dec_nib = 4'h6;
            7'h70:   dec_nib = 4'h7;
            7'h7F:   dec_nib = 4'h8;
            7'h7B:   dec_nib = 4'h9;
            7'h00:   dec_nib = 4'hF;
            default: begin
                dec_nib = 4'hE;
                dec_ill = 1'b1;
            end
        endcase
    end

    // Convert the one-hot digit select into a slot index.
    always_comb begin
        case (s_an_q)
            4'b0010: slot_idx = 2'd1;
            4'b0100: slot_idx = 2'd2;
            4'b1000: slot_idx = 2'd3;
            default: slot_idx = 2'd0;
        endcase
    end

    // Capture, slot update and frame completion for this edge.
    always_comb begin
        capture    = (state_q == ST_QUALIFY) && (cnt_d == CNT_MAX) && $onehot(s_an_q);
        slot_d     = slot_q;
        mask_d     = mask_q;
        err_pend_d = err_pend_q;
        if (capture) begin
            slot_d[slot_idx] = dec_nib;
            mask_d           = mask_q | (4'b0001 << slot_idx);
            err_pend_d       = err_pend_q | dec_ill;
        end
        publish = capture && (mask_d == 4'hF);
    end

    // Dwell state machine: allow one capture per stable dwell.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_QUALIFY;
        end else begin
            case (state_q)
                ST_QUALIFY: if (capture)        state_q <= ST_HELD;
                ST_HELD:    if (cnt_d == 8'd0)  state_q <= ST_QUALIFY;
                default:                        state_q <= ST_QUALIFY;
            endcase
        end
    end

    // Input stage, slot store and frame publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg_q       <= 7'd0;
            s_an_q        <= 4'd0;
            cnt_q         <= 8'd0;
            slot_q        <= '0;
            mask_q        <= 4'd0;
            err_pend_q    <= 1'b0;
            digits_q      <= 16'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            s_seg_q       <= bus.seg;
            s_an_q        <= bus.an;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            frame_valid_q <= publish;
            if (publish) begin
                digits_q    <= slot_d;
                frame_err_q <= err_pend_d;
                mask_q      <= 4'd0;
                err_pend_q  <= 1'b0;
            end else begin
                mask_q      <= mask_d;
                err_pend_q  <= err_pend_d;
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture.
// Directed display scenarios are followed by random dwells. All outputs are
// checked against a run-length based reference model every cycle.
module tb_seg7_capture;

    localparam int STABLE = 4;

    logic clk;
    logic reset;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // reference model state
    logic [3:0]  m_prev_an;
    logic [6:0]  m_prev_seg;
    int          m_run;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_mask;
    logic        m_pend;
    logic [15:0] e_digits;
    logic        e_err;
    logic        e_valid;
    int          strobes;
    int          prev_valid;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        // {illegal, nibble}
        case (s)
            7'h7E: return 5'h00;
            7'h30: return 5'h01;
            7'h6D: return 5'h02;
            7'h79: return 5'h03;
            7'h33: return 5'h04;
            7'h5B: return 5'h05;
            7'h5F: return 5'h06;
            7'h70: return 5'h07;
            7'h7F: return 5'h08;
            7'h7B: return 5'h09;
            7'h00: return 5'h0F;
            default: return 5'h1E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_an  = 4'd0;
        m_prev_seg = 7'd0;
        m_run      = 0;
        m_mask     = 4'd0;
        m_pend     = 1'b0;
        for (int i = 0; i < 4; i++) m_slot[i] = 4'd0;
        e_digits   = 16'd0;
        e_err      = 1'b0;
        e_valid    = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then check all outputs.
    task automatic cyc(input logic [3:0] a, input logic [6:0] s, input logic r);
        logic [4:0] dec;
        int idx;
        bus.an  = a;
        bus.seg = s;
        reset   = r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if ($countones(a) == 1 && a == m_prev_an && s == m_prev_seg)
                m_run++;
            else
                m_run = ($countones(a) == 1) ? 1 : 0;
            m_prev_an  = a;
            m_prev_seg = s;
            e_valid    = 1'b0;
            if (m_run == STABLE) begin
                dec = ref_decode(s);
                idx = 0;
                for (int i = 0; i < 4; i++) if (a[i]) idx = i;
                m_slot[idx] = dec[3:0];
                m_mask[idx] = 1'b1;
                m_pend      = m_pend | dec[4];
                if (m_mask == 4'hF) begin
                    e_digits = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                    e_err    = m_pend;
                    e_valid  = 1'b1;
                    m_mask   = 4'd0;
                    m_pend   = 1'b0;
                end
            end
        end
        #1;
        chk("frame_valid", 16'(bus.frame_valid), 16'(e_valid));
        chk("digits", bus.digits, e_digits);
        chk("frame_err", 16'(bus.frame_err), 16'(e_err));
        if (bus.frame_valid === 1'b1) begin
            strobes++;
            chk("valid_not_back_to_back", 16'(prev_valid), 16'd0);
        end
        prev_valid = (bus.frame_valid === 1'b1) ? 1 : 0;
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(a, s, 1'b0);
    endtask

    logic [6:0] seg_tab [12];
    int         st;

    initial begin
        seg_tab[0] = 7'h7E; seg_tab[1] = 7'h30; seg_tab[2]  = 7'h6D; seg_tab[3]  = 7'h79;
        seg_tab[4] = 7'h33; seg_tab[5] = 7'h5B; seg_tab[6]  = 7'h5F; seg_tab[7]  = 7'h70;
        seg_tab[8] = 7'h7F; seg_tab[9] = 7'h7B; seg_tab[10] = 7'h00; seg_tab[11] = 7'h7C;
        strobes    = 0;
        prev_valid = 0;
        model_reset();
        bus.an  = 4'd0;
        bus.seg = 7'd0;
        reset   = 1'b1;

        // basic frame, 4-cycle dwells
        cyc(4'b0000, 7'h00, 1'b1);
        cyc(4'b0000, 7'h00, 1'b1);
        chk("reset_digits", bus.digits, 16'h0000);
        chk("reset_valid", 16'(bus.frame_valid), 16'd0);
        strobes = 0;
        dwell(4'b0001, 7'h7E, 4);
        dwell(4'b0010, 7'h30, 4);
        dwell(4'b0100, 7'h6D, 4);
        dwell(4'b1000, 7'h79, 4);
        chk("s1_strobe_latency", 16'(bus.frame_valid), 16'd1);
        chk("s1_digits", bus.digits, 16'h3210);
        chk("s1_err", 16'(bus.frame_err), 16'd0);
        dwell(4'b1000, 7'h79, 6);
        chk("s1_strobes", 16'(strobes), 16'd1);

        // 3-cycle dwells never qualify
        cyc(4'b0000, 7'h00, 1'b1);
        strobes = 0;
        dwell(4'b0001, 7'h7E, 3);
        dwell(4'b0010, 7'h30, 3);
        dwell(4'b0100, 7'h6D, 3);
        dwell(4'b1000, 7'h79, 3);
        dwell(4'b0000, 7'h00, 3);
        chk("s2_strobes", 16'(strobes), 16'd0);
        chk("s2_digits", bus.digits, 16'h0000);

        // blank and illegal slots, then a clean frame
        strobes = 0;
        dwell(4'b0001, 7'h7F, 4);
        dwell(4'b0010, 7'h7C, 4);
        dwell(4'b0100, 7'h00, 4);
        dwell(4'b1000, 7'h7F, 4);
        chk("s3_digits", bus.digits, 16'h8FE8);
        chk("s3_err", 16'(bus.frame_err), 16'd1);
        dwell(4'b0001, 7'h7B, 4);
        dwell(4'b0010, 7'h7B, 4);
        dwell(4'b0100, 7'h7B, 4);
        dwell(4'b1000, 7'h7B, 4);
        chk("s3_clean_digits", bus.digits, 16'h9999);
        chk("s3_clean_err", 16'(bus.frame_err), 16'd0);
        chk("s3_strobes", 16'(strobes), 16'd2);

        // non-one-hot selects interleaved with valid dwells
        cyc(4'b0000, 7'h00, 1'b1);
        strobes = 0;
        dwell(4'b0001, 7'h7E, 4);
        dwell(4'b0011, 7'h7E, 20);
        dwell(4'b0010, 7'h30, 4);
        dwell(4'b0000, 7'h7E, 20);
        dwell(4'b0100, 7'h6D, 4);
        dwell(4'b0011, 7'h7E, 20);
        dwell(4'b1000, 7'h79, 4);
        chk("s4_digits", bus.digits, 16'h3210);
        chk("s4_strobes", 16'(strobes), 16'd1);

        // slot rewrite, latest wins; long hold gives no extra strobe
        cyc(4'b0000, 7'h00, 1'b1);
        strobes = 0;
        dwell(4'b0001, 7'h5B, 4);
        dwell(4'b0001, 7'h5F, 4);
        dwell(4'b0010, 7'h70, 4);
        dwell(4'b0100, 7'h70, 4);
        dwell(4'b1000, 7'h70, 30);
        chk("s5_digits", bus.digits, 16'h7776);
        chk("s5_strobes", 16'(strobes), 16'd1);

        // reset mid-frame discards the partial frame
        cyc(4'b0000, 7'h00, 1'b1);
        strobes = 0;
        dwell(4'b0001, 7'h7E, 4);
        dwell(4'b0010, 7'h30, 4);
        dwell(4'b0100, 7'h6D, 4);
        cyc(4'b0100, 7'h6D, 1'b1);
        dwell(4'b1000, 7'h79, 10);
        chk("s6_strobes", 16'(strobes), 16'd0);
        chk("s6_digits", bus.digits, 16'h0000);

        // random dwells against the model
        for (int d = 0; d < 400; d++) begin
            logic [3:0] a;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 4'b0001 << $urandom_range(0, 3);
            else if (r == 8) a = 4'b0000;
            else             a = 4'($urandom);
            st = int'($urandom_range(0, 11));
            if ($urandom_range(0, 99) == 0)
                cyc(a, seg_tab[st], 1'b1);
            else
                dwell(a, seg_tab[st], int'($urandom_range(1, 6)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the BCD-to-7-segment display path. It observes a multiplexed 4-digit 7-segment drive (segment lines plus one-hot digit select) and requires each (select, pattern) pair to be stable before accepting it. It decodes each accepted pattern back to BCD and publishes a complete 4-digit frame with a one-cycle valid strobe. It is used as a loopback checker and readback monitor for the display subsystem.

## Interface
- STABLE_CYCLES, 4: consecutive identical registered samples required before capture; legal range 2..255.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- seg  in  7  segment drive, active-high; bit 6 = a, bit 5 = b … bit 0 = g.
- an  in  4  digit select, active-high one-hot; an[i] selects digit slot i.
- digits  out  16  last published frame; slot i at [4i+3:4i].
- frame_valid  out  1  one-cycle strobe when `digits` and `frame_err` update.
- frame_err  out  1  at least one slot in the published frame held an illegal pattern.

## Operation
- Input stage: `seg` and `an` are registered every cycle into `s_seg` and `s_an`. Decoding uses only these registered copies.
- Pattern decode: 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 00→F (blank). Any other pattern decodes to E and marks the slot illegal.
- Stability counter, 8 bits:
  - Cleared to 0 when the current registered sample differs from the previous one, or when `s_an` is not exactly one-hot (zero bits or more than one bit set).
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- State machine, per dwell:
  - QUALIFY: when the counter equals STABLE_CYCLES-1 and `s_an` is one-hot, capture the decoded nibble into slot index(s_an), set mask[index], OR the illegal flag into the pending error, then go to HELD.
  - HELD: no further capture. Return to QUALIFY when the sample changes or becomes non-one-hot.
- Slot rewrite: a slot captured again before the frame completes is overwritten (latest wins). Its previous illegal contribution is not removed; the pending error is sticky for the frame.
- Frame publish: on the edge where the capture makes mask = 1111:
  - `digits` ← all four slot values, including this capture.
  - `frame_err` ← pending error, including this capture.
  - `frame_valid` = 1 for the following cycle.
  - mask and pending error are cleared.
- Outputs hold between publishes.
- Reset:
  - Outputs: `digits`=0000, `frame_valid`=0, `frame_err`=0.
  - Internal: mask=0, pending error=0, counter=0, state=QUALIFY, slot registers=0, `s_seg`/`s_an`=0.
  - Reset asserted mid-frame discards the partial frame. No publish occurs until four new captures complete.

## Timing
- If (`an`, `seg`) is first presented before edge t and held, the registered sample updates at edge t. The capture registers at edge t+STABLE_CYCLES-1.
- For a completing capture, `digits`, `frame_err` and `frame_valid` update at that same edge. Latency from input change to strobe is STABLE_CYCLES cycles.
- A dwell shorter than STABLE_CYCLES cycles is never captured.
- A glitch of 1 cycle restarts qualification. The following dwell must again last STABLE_CYCLES cycles.
- Holding one digit indefinitely produces exactly one capture.
- Re-presenting the same digit/pattern after any intervening change counts as a new dwell.
- Back-to-back frames: the capture completing frame N and the first capture of frame N+1 may occur on consecutive dwells. `frame_valid` is never high for two consecutive cycles.

## Test plan
- Reset, then drive an=0001/7E, 0010/30, 0100/6D, 1000/79 for 4 cycles each → single `frame_valid` after the last dwell, digits=16'h3210, frame_err=0, latency 4 cycles from the last change.
- Same sequence with each dwell 3 cycles → no capture, `frame_valid` never asserts, digits stays 0000.
- Slot 2 driven 00 (blank), slot 1 driven 7C (illegal), others 7F → digits=16'h8FE8, frame_err=1. A following clean frame with all 7B → digits=16'h9999, frame_err=0.
- an=0011 or an=0000 held 20 cycles with 7E, interleaved with valid dwells → those intervals never capture. The frame completes only from the valid dwells.
- Slot 0 captured as 5B, then recaptured as 5F, then slots 1–3 as 70 → digits=16'h7776. One strobe only; an indefinitely held dwell yields no extra strobe.
- Three slots captured, reset asserted 1 cycle, then slot 3 captured alone → no strobe. All four slots are required after reset before digits updates from 0000.
